// File: rtl/add5_arbiter.sv
// add5_arbiter: two-requester front end for a shared 5-bit adder.
// Fair tie-break, one operation per IDLE/RUN/DONE round.
module add5_arbiter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin0,
  input  logic             cin1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_e,
  output logic             add_stop,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_c
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             win_q, win_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic             pick1;
  logic             busy_d;

  // requester 1 wins when alone, or on a tie when 0 was served last
  assign pick1 = req1 & (~req0 | ~last_q);

  // next-state, arbitration, operand capture and result capture
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    last_d   = last_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    cin_d    = cin_q;
    result_d = result_q;
    cout_d   = cout_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = RUN;
          win_d   = pick1;
          last_d  = pick1;
          opa_d   = pick1 ? a1 : a0;
          opb_d   = pick1 ? b1 : b0;
          cin_d   = pick1 ? cin1 : cin0;
        end
      end
      RUN: begin
        state_d  = DONE;
        result_d = add_s;
        cout_d   = add_c;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // grant and done are registered, decoded from the upcoming state
  always_comb begin
    busy_d    = (state_d == RUN) | (state_d == DONE);
    gnt_d     = 2'b00;
    done_d    = 2'b00;
    gnt_d[0]  = busy_d & ~win_d;
    gnt_d[1]  = busy_d & win_d;
    done_d[0] = (state_d == DONE) & ~win_d;
    done_d[1] = (state_d == DONE) & win_d;
  end

  // state registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      win_q    <= 1'b0;
      last_q   <= 1'b1;
      opa_q    <= '0;
      opb_q    <= '0;
      cin_q    <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      last_q   <= last_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      cin_q    <= cin_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
    end
  end

  // shared adder drive: live only in RUN, killed otherwise
  always_comb begin
    add_a    = '0;
    add_b    = '0;
    add_e    = 1'b0;
    add_stop = 1'b1;
    if (state_q == RUN) begin
      add_a    = opa_q;
      add_b    = opb_q;
      add_e    = cin_q;
      add_stop = 1'b0;
    end
  end

  assign gnt0   = gnt_q[0];
  assign gnt1   = gnt_q[1];
  assign done0  = done_q[0];
  assign done1  = done_q[1];
  assign result = result_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_add5_arbiter.sv
// tb_add5_arbiter: directed bench with an expected-result queue.
// Models the external ripple adder behind add_* / add_s / add_c.
module tb_add5_arbiter;

  typedef struct packed {
    logic       w;
    logic [4:0] r;
    logic       c;
  } exp_t;

  logic       clk;
  logic       Reset;
  logic       req0, req1;
  logic [4:0] a0, b0, a1, b1;
  logic       cin0, cin1;
  logic       gnt0, gnt1, done0, done1;
  logic [4:0] result;
  logic       cout;
  logic [4:0] add_a, add_b;
  logic       add_e, add_stop;
  logic [4:0] add_s;
  logic       add_c;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  exp_t sb[$];
  int   dcyc[$];

  add5_arbiter #(.WIDTH(5)) dut (
    .clk(clk), .Reset(Reset),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .cin0(cin0), .cin1(cin1),
    .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1),
    .result(result), .cout(cout),
    .add_a(add_a), .add_b(add_b),
    .add_e(add_e), .add_stop(add_stop),
    .add_s(add_s), .add_c(add_c)
  );

  assign {add_c, add_s} = add_stop ? 6'd0 :
    ({1'b0, add_a} + {1'b0, add_b} + {5'd0, add_e});

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_sb(input int n);
    for (int i = 0; i < n && sb.size() != 0; i++)
      @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    chk("gnt_mutex", 32'(gnt0 & gnt1), 32'd0);
    if (done0 | done1) begin
      chk("done_onehot", 32'(done0 & done1), 32'd0);
      if (sb.size() == 0) begin
        chk("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("done_who", 32'(done1), 32'(e.w));
        chk("result", 32'(result), 32'(e.r));
        chk("cout", 32'(cout), 32'(e.c));
        dcyc.push_back(cyc);
      end
    end
  end

  initial begin
    Reset = 1'b0;
    req0 = 0; req1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    cin0 = 0; cin1 = 0;

    repeat (2) @(negedge clk);
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_done0", 32'(done0), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_add_a", 32'(add_a), 32'd0);
    chk("rst_add_b", 32'(add_b), 32'd0);
    chk("rst_add_e", 32'(add_e), 32'd0);
    chk("rst_add_stop", 32'(add_stop), 32'd1);

    // single request from 0: 3+4+0
    @(posedge clk); #1 Reset = 1'b1;
    req0 = 1; a0 = 5'd3; b0 = 5'd4; cin0 = 0;
    sb.push_back({1'b0, 5'd7, 1'b0});
    @(posedge clk); #1 req0 = 0;
    @(negedge clk);
    chk("t1_run_gnt0", 32'(gnt0), 32'd1);
    chk("t1_run_gnt1", 32'(gnt1), 32'd0);
    chk("t1_run_done0", 32'(done0), 32'd0);
    chk("t1_run_add_a", 32'(add_a), 32'd3);
    chk("t1_run_add_b", 32'(add_b), 32'd4);
    chk("t1_run_add_e", 32'(add_e), 32'd0);
    chk("t1_run_stop", 32'(add_stop), 32'd0);
    @(negedge clk);
    chk("t1_done_gnt0", 32'(gnt0), 32'd1);
    chk("t1_done_done0", 32'(done0), 32'd1);
    chk("t1_done_stop", 32'(add_stop), 32'd1);
    chk("t1_done_add_a", 32'(add_a), 32'd0);
    @(negedge clk);
    chk("t1_idle_gnt0", 32'(gnt0), 32'd0);
    chk("t1_idle_done0", 32'(done0), 32'd0);
    wait_sb(10);

    // single request from 1 with carry out: 31+1+1
    @(posedge clk); #1;
    req1 = 1; a1 = 5'd31; b1 = 5'd1; cin1 = 1;
    sb.push_back({1'b1, 5'd1, 1'b1});
    @(posedge clk); #1 req1 = 0;
    @(negedge clk);
    chk("t2_run_gnt0", 32'(gnt0), 32'd0);
    chk("t2_run_gnt1", 32'(gnt1), 32'd1);
    chk("t2_run_add_a", 32'(add_a), 32'd31);
    chk("t2_run_add_e", 32'(add_e), 32'd1);
    @(negedge clk);
    chk("t2_done_gnt0", 32'(gnt0), 32'd0);
    chk("t2_done_done1", 32'(done1), 32'd1);
    chk("t2_done_done0", 32'(done0), 32'd0);
    wait_sb(10);

    // both requests held after a fresh reset: 0,1,0,1
    Reset = 1'b0;
    @(posedge clk); #1 Reset = 1'b1;
    dcyc.delete();
    req0 = 1; a0 = 5'd10; b0 = 5'd5; cin0 = 1;
    req1 = 1; a1 = 5'd20; b1 = 5'd15; cin1 = 0;
    sb.push_back({1'b0, 5'd16, 1'b0});
    sb.push_back({1'b1, 5'd3, 1'b1});
    sb.push_back({1'b0, 5'd16, 1'b0});
    sb.push_back({1'b1, 5'd3, 1'b1});
    for (int i = 0; i < 30 && sb.size() != 0; i++)
      @(negedge clk);
    req0 = 0; req1 = 0;
    chk("t3_drain", 32'(sb.size()), 32'd0);
    chk("t3_ndone", 32'(dcyc.size()), 32'd4);
    if (dcyc.size() == 4) begin
      for (int i = 0; i < 3; i++)
        chk("t3_spacing", 32'(dcyc[i+1] - dcyc[i]), 32'd3);
    end
    repeat (4) @(negedge clk);

    // drop req and change operands in RUN
    @(posedge clk); #1;
    req0 = 1; a0 = 5'd7; b0 = 5'd8; cin0 = 0;
    sb.push_back({1'b0, 5'd15, 1'b0});
    @(posedge clk); #1;
    req0 = 0; a0 = 5'd30; b0 = 5'd30; cin0 = 1;
    @(negedge clk);
    chk("t4_run_add_a", 32'(add_a), 32'd7);
    chk("t4_run_add_b", 32'(add_b), 32'd8);
    chk("t4_run_add_e", 32'(add_e), 32'd0);
    @(negedge clk);
    chk("t4_done0", 32'(done0), 32'd1);
    wait_sb(10);

    // reset in RUN drops the operation
    @(posedge clk); #1;
    req1 = 1; a1 = 5'd9; b1 = 5'd9; cin1 = 0;
    @(posedge clk); #1 req1 = 0;
    #2 Reset = 1'b0;
    #1;
    chk("t5_gnt1", 32'(gnt1), 32'd0);
    chk("t5_done1", 32'(done1), 32'd0);
    chk("t5_result", 32'(result), 32'd0);
    chk("t5_cout", 32'(cout), 32'd0);
    chk("t5_add_a", 32'(add_a), 32'd0);
    chk("t5_add_b", 32'(add_b), 32'd0);
    chk("t5_add_stop", 32'(add_stop), 32'd1);
    @(posedge clk); #1 Reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("t5_no_done_result", 32'(result), 32'd0);
    req0 = 1; a0 = 5'd1; b0 = 5'd2; cin0 = 0;
    req1 = 1; a1 = 5'd4; b1 = 5'd4; cin1 = 0;
    sb.push_back({1'b0, 5'd3, 1'b0});
    @(posedge clk); #1 req0 = 0; req1 = 0;
    @(negedge clk);
    chk("t5_tie_gnt0", 32'(gnt0), 32'd1);
    chk("t5_tie_gnt1", 32'(gnt1), 32'd0);
    wait_sb(10);

    // idle with no requests: adder killed, result held
    repeat (3) begin
      @(negedge clk);
      chk("t6_stop", 32'(add_stop), 32'd1);
      chk("t6_add_a", 32'(add_a), 32'd0);
      chk("t6_add_b", 32'(add_b), 32'd0);
      chk("t6_result", 32'(result), 32'd3);
      chk("t6_cout", 32'(cout), 32'd0);
      chk("t6_gnt", 32'({gnt1, gnt0}), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
